// File: rtl/prbs17_pkg.sv
// Shared constants and FSM encoding for the PRBS17 link checker.
package prbs17_pkg;

  localparam int WORD_W      = 16;
  localparam int HIST_W      = 2 * WORD_W;
  localparam int PRBS_TAP_A  = 17;  // x^17 term: the new bit depends on the bit 17 back
  localparam int PRBS_TAP_B  = 14;  // x^14 term
  localparam int PRIME_WORDS = 2;
  localparam int POP_W       = 5;   // enough to hold a popcount of 0..16

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

endpackage

// File: rtl/prbs17_err_detect.sv
// Self-synchronising PRBS17 error detector.
// It checks every bit of the new word against the two bits 17 and 14
// positions earlier in the received stream, so no seed is needed.
module prbs17_err_detect
  import prbs17_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  input  logic [HIST_W-1:0] hist_i,
  output logic [WORD_W-1:0] err_o,
  output logic [POP_W-1:0]  pop_o
);

  localparam int EXT_W   = WORD_W + PRBS_TAP_A;
  localparam int TAP_GAP = PRBS_TAP_A - PRBS_TAP_B;

  // Only the newest 17 history bits take part in the check.
  logic [EXT_W-1:0] ext;
  logic             unused_hist;

  assign ext         = {data_i, hist_i[HIST_W-1:HIST_W-PRBS_TAP_A]};
  assign unused_hist = ^hist_i[HIST_W-PRBS_TAP_A-1:0];

  // A single flipped line bit can raise up to three flags across two words.
  for (genvar gi = 0; gi < WORD_W; gi++) begin : g_err
    assign err_o[gi] = ext[gi] ^ ext[gi + TAP_GAP] ^ ext[gi + PRBS_TAP_A];
  end

  // Count the error flags of the current word.
  always_comb begin
    pop_o = '0;
    for (int i = 0; i < WORD_W; i++) begin
      pop_o = pop_o + POP_W'(err_o[i]);
    end
  end

endmodule

// File: rtl/prbs17_link_checker.sv
// PRBS17 test sequencer and checker: runs the generator for a programmed
// number of words, checks the looped-back stream, tracks lock and counts errors.
module prbs17_link_checker
  import prbs17_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int LOCK_WORDS  = 8,
  parameter int UNLOCK_ERRS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  test_len,
  output logic              prbs_dis,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_word_cnt,
  output logic [CNT_W-1:0]  err_bit_cnt
);

  localparam int RUN_MAX = (LOCK_WORDS > UNLOCK_ERRS) ? LOCK_WORDS : UNLOCK_ERRS;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam int PRIME_W = $clog2(PRIME_WORDS + 1);

  state_e             state_q;
  logic [CNT_W-1:0]   len_q;
  logic [PRIME_W-1:0] prime_q;
  logic [HIST_W-1:0]  hist_q, hist_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]   err_word_q, err_word_d;
  logic [CNT_W-1:0]   err_bit_q, err_bit_d;
  logic [CNT_W:0]     bit_sum;
  logic [RUN_W-1:0]   good_q, good_d;
  logic [RUN_W-1:0]   bad_q, bad_d;
  logic               locked_q, locked_d;
  logic               done_q, busy_q, dis_q;
  logic [WORD_W-1:0]  err_vec;
  logic [POP_W-1:0]   err_pop;
  logic               err_any;

  prbs17_err_detect u_err_detect (
    .data_i (data_in),
    .hist_i (hist_q),
    .err_o  (err_vec),
    .pop_o  (err_pop)
  );

  assign err_any = |err_vec;
  assign hist_d  = {data_in, hist_q[HIST_W-1:WORD_W]};

  // Next values of the counters and lock state for a checked word.
  always_comb begin
    word_cnt_d = word_cnt_q + CNT_W'(1);
    err_word_d = err_word_q;
    if (err_any && (err_word_q != '1)) begin
      err_word_d = err_word_q + CNT_W'(1);
    end
    bit_sum   = {1'b0, err_bit_q} + (CNT_W + 1)'(err_pop);
    err_bit_d = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];

    good_d = '0;
    bad_d  = '0;
    if (err_any) begin
      bad_d = (bad_q == RUN_W'(UNLOCK_ERRS)) ? bad_q : bad_q + RUN_W'(1);
    end else begin
      good_d = (good_q == RUN_W'(LOCK_WORDS)) ? good_q : good_q + RUN_W'(1);
    end

    locked_d = locked_q;
    if (!err_any && (good_d == RUN_W'(LOCK_WORDS))) begin
      locked_d = 1'b1;
    end else if (err_any && (bad_d == RUN_W'(UNLOCK_ERRS))) begin
      locked_d = 1'b0;
    end
  end

  // Test sequencer FSM with registered status outputs, history and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      prime_q    <= '0;
      hist_q     <= '0;
      word_cnt_q <= '0;
      err_word_q <= '0;
      err_bit_q  <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      locked_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      dis_q      <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_q    <= ST_PRIME;
            len_q      <= test_len;
            prime_q    <= '0;
            word_cnt_q <= '0;
            err_word_q <= '0;
            err_bit_q  <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            locked_q   <= 1'b0;
            busy_q     <= 1'b1;
            dis_q      <= 1'b0;
          end
        end
        ST_PRIME: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            dis_q   <= 1'b1;
          end else if (data_valid) begin
            hist_q  <= hist_d;
            prime_q <= prime_q + PRIME_W'(1);
            if (prime_q == PRIME_W'(PRIME_WORDS - 1)) begin
              state_q <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            dis_q   <= 1'b1;
          end else if (data_valid) begin
            hist_q     <= hist_d;
            word_cnt_q <= word_cnt_d;
            err_word_q <= err_word_d;
            err_bit_q  <= err_bit_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            locked_q   <= locked_d;
            if ((len_q != '0) && (word_cnt_d == len_q)) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              dis_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          dis_q   <= 1'b1;
        end
      endcase
    end
  end

  assign prbs_dis     = dis_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign locked       = locked_q;
  assign word_cnt     = word_cnt_q;
  assign err_word_cnt = err_word_q;
  assign err_bit_cnt  = err_bit_q;

endmodule

// File: tb/tb_prbs17_link_checker.sv
// Bench for prbs17_link_checker: a stream-level model of the checker plus
// directed scenarios with hand-computed expectations.
module tb_prbs17_link_checker;

  localparam int CNT_W = 32;

  logic              clk = 1'b0;
  logic              reset, start, abort, data_valid;
  logic [CNT_W-1:0]  test_len;
  logic [15:0]       data_in;
  logic              prbs_dis, busy, done, locked;
  logic [CNT_W-1:0]  word_cnt, err_word_cnt, err_bit_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  prbs17_link_checker #(
    .CNT_W       (CNT_W),
    .LOCK_WORDS  (8),
    .UNLOCK_ERRS (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .test_len     (test_len),
    .prbs_dis     (prbs_dis),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .busy         (busy),
    .done         (done),
    .locked       (locked),
    .word_cnt     (word_cnt),
    .err_word_cnt (err_word_cnt),
    .err_bit_cnt  (err_bit_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // PRBS17 source: s[n+17] = s[n] ^ s[n+3]; gen_q[0] is the oldest bit.
  logic [16:0] gen_q = 17'h1ACE1;
  task automatic gen_word(output logic [15:0] w);
    logic nb;
    for (int b = 0; b < 16; b++) begin
      nb     = gen_q[0] ^ gen_q[3];
      gen_q  = {nb, gen_q[16:1]};
      w[b]   = nb;
    end
  endtask

  // Stream-level model of the checker.
  bit          m_testing;
  int          m_prime_left;
  logic [31:0] m_len, m_wc, m_ew, m_eb;
  bit          m_locked, m_done;
  bit          rx[$];     // received bits of this test, oldest first
  bit          flags[$];  // one entry per checked word, 1 = errored

  task automatic model_reset();
    m_testing = 0; m_prime_left = 0; m_len = 0;
    m_wc = 0; m_ew = 0; m_eb = 0; m_locked = 0; m_done = 0;
    rx.delete(); flags.delete();
  endtask

  task automatic model_edge(input bit st, input bit ab, input bit v,
                            input logic [15:0] w, input logic [31:0] len);
    int base, nerr, run;
    m_done = 0;
    if (!m_testing) begin
      if (st && !ab) begin
        m_testing = 1; m_len = len; m_wc = 0; m_ew = 0; m_eb = 0;
        m_locked = 0; rx.delete(); flags.delete(); m_prime_left = 2;
      end
    end else if (ab) begin
      m_testing = 0;
    end else if (v) begin
      base = rx.size();
      for (int b = 0; b < 16; b++) rx.push_back(w[b]);
      if (m_prime_left > 0) begin
        m_prime_left--;
      end else begin
        nerr = 0;
        for (int b = 0; b < 16; b++)
          if (rx[base+b] ^ rx[base+b-14] ^ rx[base+b-17]) nerr++;
        m_wc++;
        if (nerr != 0) m_ew++;
        m_eb += nerr;
        flags.push_back(nerr != 0);
        run = 0;
        for (int k = flags.size() - 1; k >= 0 && run < 8 && flags[k] == flags[flags.size()-1]; k--)
          run++;
        if (!flags[flags.size()-1] && run >= 8) m_locked = 1;
        if (flags[flags.size()-1] && run >= 4) m_locked = 0;
        if (m_len != 0 && m_wc == m_len) begin
          m_done = 1;
          m_testing = 0;
        end
      end
    end
  endtask

  // Compare all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("prbs_dis", prbs_dis, !m_testing);
      check("busy", busy, m_testing);
      check("done", done, m_done);
      check("locked", locked, m_locked);
      check("word_cnt", word_cnt, m_wc);
      check("err_word_cnt", err_word_cnt, m_ew);
      check("err_bit_cnt", err_bit_cnt, m_eb);
    end
  end

  task automatic step(input bit st, input bit ab, input bit v, input logic [15:0] w);
    start = st; abort = ab; data_valid = v; data_in = w;
    @(posedge clk);
    model_edge(st, ab, v, w, test_len);
    #1;
    start = 1'b0; abort = 1'b0; data_valid = 1'b0;
  endtask

  task automatic send_clean();
    logic [15:0] w;
    gen_word(w);
    step(0, 0, 1, w);
  endtask

  initial begin
    logic [15:0] w;
    reset = 1'b1; start = 1'b0; abort = 1'b0; data_valid = 1'b0;
    data_in = '0; test_len = '0;
    model_reset();
    @(posedge clk); #1;
    check("rst_prbs_dis", prbs_dis, 1);
    check("rst_busy", busy, 0);
    check("rst_locked", locked, 0);
    check("rst_word_cnt", word_cnt, 0);
    reset = 1'b0;
    cmp_en = 1'b1;

    // 1: clean stream, 100 words
    test_len = 100;
    step(1, 0, 0, '0);
    for (int k = 0; k < 102; k++) begin
      send_clean();
      if (k == 8) check("t1_unlocked_at7", locked, 0);
      if (k == 9) check("t1_locked_at8", locked, 1);
    end
    check("t1_done", done, 1);
    check("t1_word_cnt", word_cnt, 100);
    check("t1_err_words", err_word_cnt, 0);
    check("t1_err_bits", err_bit_cnt, 0);
    step(0, 0, 0, '0);
    check("t1_done_pulse", done, 0);
    check("t1_dis_after", prbs_dis, 1);

    // 2: flip bit 5 of checked word 20
    test_len = 60;
    step(1, 0, 0, '0);
    for (int k = 0; k < 62; k++) begin
      gen_word(w);
      if (k == 21) w[5] = ~w[5];
      step(0, 0, 1, w);
    end
    check("t2_done", done, 1);
    check("t2_err_bits", err_bit_cnt, 3);
    check("t2_model_err_bits", m_eb, 3);
    check("t2_err_words_1or2", (err_word_cnt == 1 || err_word_cnt == 2), 1);
    check("t2_locked", locked, 1);

    // 3: corrupt words drop lock, clean stream relocks
    test_len = 0;
    step(1, 0, 0, '0);
    for (int k = 0; k < 20; k++) send_clean();
    check("t3_locked", locked, 1);
    for (int j = 0; j < 4; j++) begin
      gen_word(w);
      w = (j % 2 == 1) ? 16'h5A5A : 16'h0000;
      step(0, 0, 1, w);
    end
    check("t3_unlocked", locked, 0);
    for (int k = 0; k < 12; k++) send_clean();
    check("t3_relocked", locked, 1);
    step(0, 1, 0, '0);

    // 4: free-running test, abort after 1000 checked words
    test_len = 0;
    step(1, 0, 0, '0);
    for (int k = 0; k < 1002; k++) send_clean();
    check("t4_word_cnt", word_cnt, 1000);
    step(0, 1, 0, '0);
    check("t4_dis", prbs_dis, 1);
    check("t4_busy", busy, 0);
    check("t4_no_done", done, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, '0);
    check("t4_held", word_cnt, 1000);

    // 5: start during CHECK ignored; start+abort in IDLE
    test_len = 30;
    step(1, 0, 0, '0);
    for (int k = 0; k < 10; k++) send_clean();
    test_len = 5;
    gen_word(w);
    step(1, 0, 1, w);
    for (int k = 11; k < 32; k++) send_clean();
    check("t5_done", done, 1);
    check("t5_word_cnt", word_cnt, 30);
    step(1, 1, 0, '0);
    check("t5_sa_busy", busy, 0);
    check("t5_sa_dis", prbs_dis, 1);

    // 6: 1:1 valid gaps, then asynchronous reset mid-test
    test_len = 0;
    step(1, 0, 0, '0);
    for (int k = 0; k < 50; k++) begin
      send_clean();
      step(0, 0, 0, 16'hFFFF);
    end
    check("t6_word_cnt", word_cnt, 48);
    check("t6_locked", locked, 1);
    cmp_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_dis", prbs_dis, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_locked", locked, 0);
    check("t6_rst_word_cnt", word_cnt, 0);
    check("t6_rst_err_words", err_word_cnt, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    cmp_en = 1'b1;
    for (int k = 0; k < 3; k++) step(0, 0, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
